// File: rtl/jericalla_gen2.sv
// ---------------------------------------------------------------------------
// jericalla_gen2 -- three-stage register/RAM micro-datapath
//
// Executes one instruction word per accepted transfer through:
//   stage 0 (decode, combinational register read with write-through)
//   buffer 1 -> stage 1 (execute: ALU or RAM address)
//   buffer 2 -> stage 2 (RAM access, register write-back)
//
// Instruction word (INSTR_W = 3 + 3*REG_AW bits, MSB first):
//   opcode[2:0] | WA | RA1 | RA2
//   000 LI   WA <= zero-extended {RA1,RA2}
//   001 ADD  010 SUB  011 AND  100 OR  101 SLT (unsigned, 1/0)
//   110 SW   RAM[DR1] <= DR2 (no register write)
//   111 LW   WA <= RAM[DR1]
//
// Ports:
//   clk_jericalla      in   clock, rising edge
//   rst_n_jericalla    in   asynchronous active-low reset
//   instr_valid        in   instruccion is presented this cycle
//   instr_ready        out  instruction accepted at the coming edge
//   instruccion        in   instruction word
//   zf_jericalla       out  zero flag of the last ALU operation
//   dataOut_jericalla  out  RAM read data while an LW is in stage 2, else 0
//   wb_valid           out  register write-back at the next edge
//   wb_addr            out  write-back register address
//   wb_data            out  write-back value
//
// Build option:
//   JERICALLA_FWD_EN  defined   -> the buffer-1 result is forwarded into the
//                                  decode operands; only a load-use match
//                                  stalls.
//                     undefined -> any source matching a register-writing
//                                  instruction in buffer 1 stalls one cycle.
// ---------------------------------------------------------------------------
module jericalla_gen2 #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int RAM_AW = 5,
    localparam int INSTR_W = 3 + 3*REG_AW
) (
    input  logic               clk_jericalla,
    input  logic               rst_n_jericalla,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instruccion,
    output logic               zf_jericalla,
    output logic [DATA_W-1:0]  dataOut_jericalla,
    output logic               wb_valid,
    output logic [REG_AW-1:0]  wb_addr,
    output logic [DATA_W-1:0]  wb_data
);

    localparam logic [2:0] OP_LI  = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SW  = 3'b110;
    localparam logic [2:0] OP_LW  = 3'b111;

    localparam int IMM_W = 2*REG_AW;
    localparam int EXT_W = (DATA_W > IMM_W) ? DATA_W : IMM_W;

    // ------------------------------------------------------------------
    // Opcode classification and ALU
    // ------------------------------------------------------------------
    function automatic logic uses_ra1(input logic [2:0] op);
        return (op != OP_LI);
    endfunction

    // LW reads only its address register; LI reads nothing.
    function automatic logic uses_ra2(input logic [2:0] op);
        return (op != OP_LI) && (op != OP_LW);
    endfunction

    function automatic logic writes_reg(input logic [2:0] op);
        return (op != OP_SW);
    endfunction

    function automatic logic is_alu(input logic [2:0] op);
        return (op >= OP_ADD) && (op <= OP_SLT);
    endfunction

    // LI travels with its immediate in operand a, so it passes straight through.
    function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SLT:  r = DATA_W'(a < b);
            OP_LI:   r = a;
            default: r = '0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs [2**REG_AW];
    logic [DATA_W-1:0] ram  [2**RAM_AW];

    logic              vld_p1;
    logic [2:0]        op_p1;
    logic [REG_AW-1:0] wa_p1;
    logic [DATA_W-1:0] dr1_p1;
    logic [DATA_W-1:0] dr2_p1;

    logic              vld_p2;
    logic [2:0]        op_p2;
    logic [REG_AW-1:0] wa_p2;
    logic [DATA_W-1:0] dr2_p2;
    logic [RAM_AW-1:0] addr_p2;
    logic [DATA_W-1:0] res_p2;

    logic              zf_q;

    // Stage 1 combinational results (declared early: decode forwards from them)
    logic [DATA_W-1:0] alu_a_p1;
    logic [RAM_AW-1:0] addr_p1;
    logic [DATA_W-1:0] res_p1;

    // ------------------------------------------------------------------
    // Stage 0: decode and operand read
    // ------------------------------------------------------------------
    logic [2:0]        op_p0;
    logic [REG_AW-1:0] wa_p0;
    logic [REG_AW-1:0] ra1_p0;
    logic [REG_AW-1:0] ra2_p0;
    logic [EXT_W-1:0]  imm_ext_p0;
    logic [DATA_W-1:0] rf1_p0;
    logic [DATA_W-1:0] rf2_p0;
    logic [DATA_W-1:0] opnd1_p0;
    logic [DATA_W-1:0] opnd2_p0;
    logic [DATA_W-1:0] dr1_p0;
    logic              match1_p0;
    logic              match2_p0;
    logic              hazard_p0;
    logic              transfer;

    assign op_p0      = instruccion[INSTR_W-1 -: 3];
    assign wa_p0      = instruccion[3*REG_AW-1 -: REG_AW];
    assign ra1_p0     = instruccion[2*REG_AW-1 -: REG_AW];
    assign ra2_p0     = instruccion[REG_AW-1:0];
    assign imm_ext_p0 = EXT_W'(instruccion[IMM_W-1:0]);

    // Write-through: the value retiring at the coming edge is visible now.
    assign rf1_p0 = (wb_valid && (wb_addr == ra1_p0)) ? wb_data : regs[ra1_p0];
    assign rf2_p0 = (wb_valid && (wb_addr == ra2_p0)) ? wb_data : regs[ra2_p0];

    // Source fields that collide with the destination of the buffer-1 writer
    assign match1_p0 = vld_p1 && writes_reg(op_p1) && uses_ra1(op_p0) && (wa_p1 == ra1_p0);
    assign match2_p0 = vld_p1 && writes_reg(op_p1) && uses_ra2(op_p0) && (wa_p1 == ra2_p0);

`ifdef JERICALLA_FWD_EN
    // Buffer 1 is younger than buffer 2, so its result takes priority over
    // the write-through path. A load's data does not exist until stage 2,
    // so a matching LW still has to stall.
    assign opnd1_p0  = (match1_p0 && (op_p1 != OP_LW)) ? res_p1 : rf1_p0;
    assign opnd2_p0  = (match2_p0 && (op_p1 != OP_LW)) ? res_p1 : rf2_p0;
    assign hazard_p0 = instr_valid && (op_p1 == OP_LW) && (match1_p0 || match2_p0);
`else
    assign opnd1_p0  = rf1_p0;
    assign opnd2_p0  = rf2_p0;
    assign hazard_p0 = instr_valid && (match1_p0 || match2_p0);
`endif

    // LI carries its immediate in the DR1 slot.
    assign dr1_p0 = (op_p0 == OP_LI) ? imm_ext_p0[DATA_W-1:0] : opnd1_p0;

    // Reset pulls ready low directly; a stall lasts one cycle because the
    // offending instruction leaves buffer 1 at the next edge.
    assign instr_ready = rst_n_jericalla && !hazard_p0;
    assign transfer    = instr_valid && instr_ready;

    // ------------------------------------------------------------------
    // Buffer 1 (stage 0 -> stage 1)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
        if (!rst_n_jericalla) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= transfer;
        end
    end

    always_ff @(posedge clk_jericalla) begin
        if (transfer) begin
            op_p1  <= op_p0;
            wa_p1  <= wa_p0;
            dr1_p1 <= dr1_p0;
            dr2_p1 <= opnd2_p0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: execute (DR1 steered to the ALU or to the RAM address)
    // ------------------------------------------------------------------
    always_comb begin
        alu_a_p1 = dr1_p1;
        addr_p1  = '0;
        if ((op_p1 == OP_SW) || (op_p1 == OP_LW)) begin
            alu_a_p1 = '0;
            addr_p1  = dr1_p1[RAM_AW-1:0];
        end
    end

    assign res_p1 = alu(op_p1, alu_a_p1, dr2_p1);

    // ------------------------------------------------------------------
    // Buffer 2 (stage 1 -> stage 2)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
        if (!rst_n_jericalla) begin
            vld_p2 <= 1'b0;
            zf_q   <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1 && is_alu(op_p1)) begin
                zf_q <= (res_p1 == '0);
            end
        end
    end

    always_ff @(posedge clk_jericalla) begin
        op_p2   <= op_p1;
        wa_p2   <= wa_p1;
        dr2_p2  <= dr2_p1;
        addr_p2 <= addr_p1;
        res_p2  <= res_p1;
    end

    // ------------------------------------------------------------------
    // Stage 2: RAM access and register write-back
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ram_rd_p2;

    assign ram_rd_p2 = ram[addr_p2];

    // vld_p2 is cleared asynchronously, so a store caught by reset never lands.
    always_ff @(posedge clk_jericalla) begin
        if (rst_n_jericalla && vld_p2 && (op_p2 == OP_SW)) begin
            ram[addr_p2] <= dr2_p2;
        end
    end

    assign wb_valid          = vld_p2 && writes_reg(op_p2);
    assign wb_addr           = wa_p2;
    assign wb_data           = (op_p2 == OP_LW) ? ram_rd_p2 : res_p2;
    assign dataOut_jericalla = (vld_p2 && (op_p2 == OP_LW)) ? ram_rd_p2 : '0;
    assign zf_jericalla      = zf_q;

    always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
        if (!rst_n_jericalla) begin
            for (int i = 0; i < 2**REG_AW; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid) begin
            regs[wb_addr] <= wb_data;
        end
    end

endmodule

// File: tb/tb_jericalla_gen2.sv
// ---------------------------------------------------------------------------
// tb_jericalla_gen2 -- directed bench for jericalla_gen2 (DATA_W = 8)
// Register values are observed on the write-back bus; stall counts are
// observed on instr_ready while an instruction is held valid.
// ---------------------------------------------------------------------------
module tb_jericalla_gen2;

    localparam int DATA_W  = 8;
    localparam int REG_AW  = 5;
    localparam int RAM_AW  = 5;
    localparam int INSTR_W = 3 + 3*REG_AW;

`ifdef JERICALLA_FWD_EN
    localparam int FS = 0;
`else
    localparam int FS = 1;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instruccion;
    logic               zf;
    logic [DATA_W-1:0]  dout;
    logic               wb_valid;
    logic [REG_AW-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;

    int errors = 0;
    int checks = 0;
    int st;

    logic [DATA_W-1:0] obs      [2**REG_AW];
    logic [DATA_W-1:0] obs_dout [2**REG_AW];

    jericalla_gen2 #(.DATA_W(DATA_W), .REG_AW(REG_AW), .RAM_AW(RAM_AW)) dut (
        .clk_jericalla     (clk),
        .rst_n_jericalla   (rst_n),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .instruccion       (instruccion),
        .zf_jericalla      (zf),
        .dataOut_jericalla (dout),
        .wb_valid          (wb_valid),
        .wb_addr           (wb_addr),
        .wb_data           (wb_data)
    );

    always #5 clk = ~clk;

    // Record every write-back, and the data-out seen alongside it
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            obs[wb_addr]      = wb_data;
            obs_dout[wb_addr] = dout;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] enc(input logic [2:0] op, input logic [4:0] wa,
                                               input logic [4:0] ra1, input logic [4:0] ra2);
        return {op, wa, ra1, ra2};
    endfunction

    function automatic logic [INSTR_W-1:0] li(input logic [4:0] wa, input logic [9:0] imm);
        return {3'b000, wa, imm};
    endfunction

    // Present one instruction, hold it until accepted, return the stall count.
    task automatic send(input logic [INSTR_W-1:0] ins, output int stalls);
        stalls      = 0;
        instr_valid = 1'b1;
        instruccion = ins;
        #1;
        while (!instr_ready && stalls < 8) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 8) chk("accept_timeout", 32'(stalls), 32'd0);
        @(negedge clk);
        instr_valid = 1'b0;
        instruccion = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2**REG_AW; i++) begin
            obs[i]      = 8'hEE;
            obs_dout[i] = 8'hEE;
        end
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instruccion = '0;
        idle(2);
        chk("rst_ready", instr_ready, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_zf", zf, 0);
        chk("rst_dout", dout, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", instr_ready, 1);

        // Latency: buffer 1 in the first cycle, write-back visible in the next
        send(li(5'd1, 10'd5), st);
        chk("li_stall", st, 0);
        chk("lat_wb_early", wb_valid, 0);
        @(negedge clk);
        chk("lat_wb_valid", wb_valid, 1);
        chk("lat_wb_addr", wb_addr, 1);
        chk("lat_wb_data", wb_data, 5);
        idle(3);

        // LI r1,5; LI r2,5; SUB r3,r1,r2
        send(li(5'd1, 10'd5), st);
        send(li(5'd2, 10'd5), st);
        chk("li2_stall", st, 0);
        send(enc(3'b010, 5'd3, 5'd1, 5'd2), st);
        chk("sub_stall", st, FS);
        idle(4);
        chk("sub_r3", obs[3], 8'h00);
        chk("sub_zf", zf, 1);

        // Wrap: LI r1,0x3FF (truncates to 0xFF); ADD r2,r1,r1
        send(li(5'd1, 10'h3FF), st);
        send(enc(3'b001, 5'd2, 5'd1, 5'd1), st);
        chk("add_stall", st, FS);
        idle(4);
        chk("li_trunc_r1", obs[1], 8'hFF);
        chk("add_wrap_r2", obs[2], 8'hFE);
        chk("add_zf", zf, 0);

        // Unsigned SLT: 3 < 200 and 200 < 3
        send(li(5'd8, 10'd3), st);
        send(li(5'd9, 10'd200), st);
        send(enc(3'b101, 5'd10, 5'd8, 5'd9), st);
        chk("slt_stall", st, FS);
        send(enc(3'b101, 5'd11, 5'd9, 5'd8), st);
        chk("slt2_stall", st, 0);
        idle(4);
        chk("slt_r10", obs[10], 8'h01);
        chk("slt_r11", obs[11], 8'h00);
        chk("slt_zf", zf, 1);

        // OR then AND of 0x03 and 0xC8
        send(enc(3'b100, 5'd13, 5'd8, 5'd9), st);
        send(enc(3'b011, 5'd12, 5'd8, 5'd9), st);
        idle(4);
        chk("or_r13", obs[13], 8'hCB);
        chk("and_r12", obs[12], 8'h00);
        chk("and_zf", zf, 1);
        chk("dout_non_lw", obs_dout[13], 8'h00);

        // Store then load the same address
        send(li(5'd1, 10'd7), st);
        send(li(5'd2, 10'h2A), st);
        send(enc(3'b110, 5'd0, 5'd1, 5'd2), st);
        chk("sw_stall", st, FS);
        send(enc(3'b111, 5'd4, 5'd1, 5'd0), st);
        chk("lw_after_sw_stall", st, 0);
        idle(4);
        chk("lw_r4", obs[4], 8'h2A);
        chk("lw_dout", obs_dout[4], 8'h2A);
        chk("zf_held_mem", zf, 1);

        // Load-use: LW r5,r1; ADD r6,r5,r5
        send(enc(3'b111, 5'd5, 5'd1, 5'd0), st);
        send(enc(3'b001, 5'd6, 5'd5, 5'd5), st);
        chk("load_use_stall", st, 1);
        idle(4);
        chk("lu_r5", obs[5], 8'h2A);
        chk("lu_r6", obs[6], 8'h54);
        chk("lu_zf", zf, 0);

        // Reset with SUB in buffer 2 and SW r1,r6 (RAM[7] <= 0x54) in buffer 1
        send(enc(3'b010, 5'd7, 5'd1, 5'd1), st);
        send(enc(3'b110, 5'd0, 5'd1, 5'd6), st);
        chk("pre_rst_wb_valid", wb_valid, 1);
        chk("pre_rst_zf", zf, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_zf", zf, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_ready", instr_ready, 0);
        idle(2);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", instr_ready, 1);
        send(li(5'd1, 10'd7), st);
        send(enc(3'b111, 5'd3, 5'd1, 5'd0), st);
        chk("post_rst_lw_stall", st, FS);
        send(enc(3'b001, 5'd9, 5'd6, 5'd6), st);
        idle(4);
        chk("ram_kept", obs[3], 8'h2A);
        chk("regs_cleared", obs[9], 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jericalla_gen2.md
JERICALLA_GEN2 -- requirements
Module: jericalla_gen2

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register width.
REQ-002 Parameter REG_AW, default 5, register address width (bank depth 2**REG_AW).
REQ-003 Parameter RAM_AW, default 5, RAM address width (RAM depth 2**RAM_AW).
REQ-004 Derived INSTR_W = 3 + 3*REG_AW; fields: [INSTR_W-1 -: 3] opcode, then WA, RA1, RA2 (RA2 in LSBs).
REQ-005 clk_jericalla  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n_jericalla  in  1  asynchronous, active-low reset.
REQ-007 instr_valid  in  1  instruccion is presented this cycle.
REQ-008 instr_ready  out  1  block accepts instruccion at this edge; transfer = instr_valid & instr_ready.
REQ-009 instruccion  in  INSTR_W  instruction word.
REQ-010 zf_jericalla  out  1  zero flag of last retired ALU operation.
REQ-011 dataOut_jericalla  out  DATA_W  RAM read data of LW in stage 2, else 0.
REQ-012 wb_valid  out  1  register write-back occurs at the next edge.
REQ-013 wb_addr  out  REG_AW  write-back register address; wb_data  out  DATA_W  write-back value.

Function
REQ-014 Opcodes SHALL be: 000 LI (WA = zero-extended {RA1,RA2}), 001 ADD, 010 SUB, 011 AND, 100 OR, 101 SLT (unsigned, result 1/0), 110 SW (RAM[DR1[RAM_AW-1:0]] = DR2, no reg write), 111 LW (WA = RAM[DR1[RAM_AW-1:0]]).
REQ-015 Arithmetic SHALL be modulo 2**DATA_W; carries discarded.
REQ-016 Stage 0 (decode): opcode decode and register reads combinational; register file read SHALL be write-through (returns wb_data when wb_valid and wb_addr equals read address).
REQ-017 Buffer 1 SHALL capture control, WA, DR1, DR2 and a valid bit on transfer; valid clears when no transfer.
REQ-018 Stage 1 (EX): demultiplex DR1 to ALU or RAM address per opcode; ALU result combinational.
REQ-019 Buffer 2 SHALL capture Buffer 1 contents plus ALU result every edge.
REQ-020 Stage 2: SW writes RAM and write-back to registers happen at the edge ending stage 2; RAM read is combinational.
REQ-021 Latency: instruction transferred at edge k SHALL assert wb_valid in the cycle after edge k+1, register written at edge k+2.
REQ-022 zf_jericalla SHALL update at the edge loading an ALU op (001-101) into Buffer 2 to (result==0); held for LI, LW, SW, bubbles.
REQ-023 Load-use hazard: Buffer 1 holds LW with WA equal to a used RA of decode -> instr_ready=0 for exactly one cycle; bubble inserted.
REQ-024 instr_ready SHALL be 1 in all other cycles after reset; no other backpressure exists.
REQ-025 SW followed by LW to same address SHALL return the stored value.
REQ-026 Hazards SHALL compare only source fields an opcode actually uses (LI none; SW, ALU ops RA1 and RA2; LW RA1).

Reset
REQ-027 Asserting rst_n_jericalla low SHALL immediately clear both buffer valid bits, wb_valid, zf_jericalla, dataOut_jericalla and all registers to 0.
REQ-028 RAM contents SHALL NOT be reset; in-flight SW during reset SHALL NOT write.
REQ-029 instr_ready SHALL be 0 while in reset and 1 in the first cycle after release.

Configuration
REQ-030 Macro JERICALLA_FWD_EN defined: Buffer 1 ALU result forwarded into decode operands; only REQ-023 stalls.
REQ-031 Macro JERICALLA_FWD_EN undefined: any used RA matching a writing instruction in Buffer 1 SHALL stall one cycle; no forwarding logic.

Verification
REQ-032 LI r1,5; LI r2,5; SUB r3,r1,r2 back-to-back, FWD_EN -> no ready drop, r3=0, zf=1; without FWD_EN -> one ready-low cycle before SUB, same result.
REQ-033 LI r1,7; LI r2,0x2A; SW r1,r2; LW r4,r1 -> dataOut_jericalla=0x2A during LW stage 2, r4=0x2A.
REQ-034 LW r5,r1 then ADD r6,r5,r5 (RAM[7]=0x2A) -> ready low one cycle, r6=0x54.
REQ-035 LI r1,0xFFFF..; ADD r2,r1,r1 with DATA_W=8 -> r2=0xFE, zf=0 (wrap).
REQ-036 Reset asserted mid-stream with SW in Buffer 1 -> outputs 0 immediately, RAM unchanged, registers read 0 after release.
